// File: rtl/flag_status_unit_if.sv
// ---------------------------------------------------------------------------
// flag_status_unit_if
//   Bundles the decoder/ALU/call-stack controls going into the flag status
//   unit, and the flag and status outputs coming back from it.
//
//   Controls (master -> slave):
//     set_flags     decoder issues a flag-writing instruction this cycle
//     alu_valid     ALU result for the oldest flag-writing op is valid
//     alu_zero      ALU zero result, meaningful when alu_valid
//     alu_sign      ALU sign result, meaningful when alu_valid
//     alu_carry     ALU carry result, meaningful when alu_valid
//     push          save the current flags on the stack
//     pop           restore the flags from the stack top
//   Status (slave -> master):
//     fZero/fSign/fCarry  registered architectural flags
//     flags_pending       flag-writing ops outstanding, so branches must stall
//     issue_full          no more flag-writing ops may be issued
//     stack_empty         save stack holds no entries
//     stack_full          save stack has no free entries
//     flag_err            sticky protocol-error indication
// ---------------------------------------------------------------------------
interface flag_status_unit_if;
    logic set_flags;
    logic alu_valid;
    logic alu_zero;
    logic alu_sign;
    logic alu_carry;
    logic push;
    logic pop;
    logic fZero;
    logic fSign;
    logic fCarry;
    logic flags_pending;
    logic issue_full;
    logic stack_empty;
    logic stack_full;
    logic flag_err;

    // Decoder / ALU / control side.
    modport master (
        output set_flags, alu_valid, alu_zero, alu_sign, alu_carry, push, pop,
        input  fZero, fSign, fCarry, flags_pending, issue_full,
               stack_empty, stack_full, flag_err
    );

    // Flag status unit side.
    modport slave (
        input  set_flags, alu_valid, alu_zero, alu_sign, alu_carry, push, pop,
        output fZero, fSign, fCarry, flags_pending, issue_full,
               stack_empty, stack_full, flag_err
    );
endinterface

// File: rtl/flag_status_unit.sv
// ---------------------------------------------------------------------------
// flag_status_unit
//   Holds the architectural zero/sign/carry flags that feed branch decisions.
//   A small counter scoreboards flag-writing ops that have issued but whose
//   ALU result has not yet arrived, so issue can stall conditional branches.
//   A LIFO save stack lets call/return and interrupt entry/exit preserve and
//   restore the flags.
//
//   Parameters:
//     MAX_PEND     maximum outstanding flag-writing ops (>= 1)
//     STACK_DEPTH  number of save-stack entries (>= 1), each {Z,S,C}
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    flag_status_unit_if.slave: control inputs and status outputs
//
//   Every output is a register or a pure decode of register state; there is
//   no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module flag_status_unit #(
    parameter int MAX_PEND    = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flag_status_unit_if.slave     bus
);

    localparam int PendW  = $clog2(MAX_PEND + 1);
    localparam int StackW = $clog2(STACK_DEPTH + 1);

    localparam logic [PendW-1:0]  PendMax  = PendW'(MAX_PEND);
    localparam logic [StackW-1:0] StackMax = StackW'(STACK_DEPTH);

    // Architectural state.
    logic [PendW-1:0]  pendCnt;
    logic [StackW-1:0] stackCnt;
    logic [2:0]        flagReg;          // {Z,S,C}
    logic              errReg;
    logic [2:0]        stackMem [STACK_DEPTH];

    // Next-state values.
    logic [PendW-1:0]  pendNext;
    logic [StackW-1:0] stackNext;
    logic [2:0]        flagNext;
    logic              errNext;

    // Helpers.
    logic [2:0] aluFlags;
    logic [2:0] flagsAfterAlu;           // flags as they stand after the ALU update alone
    logic [2:0] stackTop;
    logic       aluLegal;
    logic       stackWrite;
    logic       pendZero;
    logic       pendFull;
    logic       stackEmpty;
    logic       stackFull;

    assign aluFlags   = {bus.alu_zero, bus.alu_sign, bus.alu_carry};
    assign pendZero   = (pendCnt == '0);
    assign pendFull   = (pendCnt == PendMax);
    assign stackEmpty = (stackCnt == '0);
    assign stackFull  = (stackCnt == StackMax);

    // A result is only accepted if an op is waiting for it; a same-cycle
    // issue counts as waiting, which keeps simultaneous set/valid legal at 0.
    assign aluLegal = bus.alu_valid && (!pendZero || bus.set_flags);

    // Stack top read: entry stackCnt-1, written as a compare loop so the
    // index width never has to match the counter width.
    always_comb begin
        stackTop = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stackCnt == StackW'(i + 1)) begin
                stackTop = stackMem[i];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        pendNext      = pendCnt;
        stackNext     = stackCnt;
        flagNext      = flagReg;
        errNext       = errReg;
        stackWrite    = 1'b0;
        flagsAfterAlu = flagReg;

        // Pending scoreboard. Simultaneous issue and completion cancel out.
        unique case ({bus.set_flags, bus.alu_valid})
            2'b10: begin
                if (pendFull) errNext  = 1'b1;
                else          pendNext = pendCnt + PendW'(1);
            end
            2'b01: begin
                if (pendZero) errNext  = 1'b1;
                else          pendNext = pendCnt - PendW'(1);
            end
            default: ;
        endcase

        if (aluLegal) begin
            flagsAfterAlu = aluFlags;
        end
        flagNext = flagsAfterAlu;

        // Push saves the post-ALU value so a result landing this cycle is
        // not lost. Push and pop together cancel with no error.
        if (bus.push && !bus.pop) begin
            if (stackFull) begin
                errNext = 1'b1;
            end else begin
                stackWrite = 1'b1;
                stackNext  = stackCnt + StackW'(1);
            end
        end

        // Pop wins over a same-cycle ALU flag update.
        if (bus.pop && !bus.push) begin
            if (stackEmpty) begin
                errNext = 1'b1;
            end else begin
                flagNext  = stackTop;
                stackNext = stackCnt - StackW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendCnt  <= '0;
            stackCnt <= '0;
            flagReg  <= '0;
            errReg   <= 1'b0;
        end else begin
            pendCnt  <= pendNext;
            stackCnt <= stackNext;
            flagReg  <= flagNext;
            errReg   <= errNext;
        end
    end

    // NOTE: the stack storage is deliberately not reset; entries are only
    // ever read below stackCnt, which reset clears, so stale contents are
    // unobservable and the array can map to plain storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stackWrite && (stackCnt == StackW'(i))) begin
                stackMem[i] <= flagsAfterAlu;
            end
        end
    end

    assign bus.fZero         = flagReg[2];
    assign bus.fSign         = flagReg[1];
    assign bus.fCarry        = flagReg[0];
    assign bus.flags_pending = !pendZero;
    assign bus.issue_full    = pendFull;
    assign bus.stack_empty   = stackEmpty;
    assign bus.stack_full    = stackFull;
    assign bus.flag_err      = errReg;

endmodule

// File: tb/tb_flag_status_unit.sv
// ---------------------------------------------------------------------------
// tb_flag_status_unit
//   Self-checking bench for flag_status_unit (MAX_PEND=4, STACK_DEPTH=4).
//   Stimulus words are {set_flags, alu_valid, Z, S, C, push, pop}; observed
//   words are {fZero, fSign, fCarry, flags_pending, issue_full, stack_empty,
//   stack_full, flag_err}. Inputs change on the falling edge and outputs are
//   sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_flag_status_unit;

    typedef struct {
        string      name;
        logic [7:0] val;
    } expEntry_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    expEntry_t sbQ[$];

    flag_status_unit_if bus ();

    flag_status_unit #(
        .MAX_PEND    (4),
        .STACK_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] obsVec();
        return {bus.fZero, bus.fSign, bus.fCarry, bus.flags_pending,
                bus.issue_full, bus.stack_empty, bus.stack_full, bus.flag_err};
    endfunction

    task automatic drive(input logic [6:0] s);
        {bus.set_flags, bus.alu_valid, bus.alu_zero, bus.alu_sign,
         bus.alu_carry, bus.push, bus.pop} = s;
    endtask

    task automatic apply_reset();
        drive(7'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        expEntry_t e;
        logic [7:0] got;
        apply_reset();
        sbQ.push_back('{"reset_release", 8'b000_00100});
        e = sbQ.pop_front();
        got = obsVec();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
        end
        drive(7'b0);
        sbQ.push_back('{"reset_idle", 8'b000_00100});
        @(negedge clk);
        e = sbQ.pop_front();
        got = obsVec();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
        end
    endtask

    task automatic test_basic_update();
        logic [6:0] stim [4];
        logic [7:0] expv [4];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b10_000_00, 7'b00_000_00, 7'b01_101_00, 7'b00_000_00};
        expv = '{8'b000_10100, 8'b000_10100, 8'b101_00100, 8'b101_00100};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("basic[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_pending_limit();
        logic [6:0] stim [10];
        logic [7:0] expv [10];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b10_000_00, 7'b10_000_00, 7'b10_000_00, 7'b10_000_00,
                 7'b11_010_00, 7'b10_000_00, 7'b01_000_00, 7'b01_000_00,
                 7'b01_000_00, 7'b01_101_00};
        expv = '{8'b000_10100, 8'b000_10100, 8'b000_10100, 8'b000_11100,
                 8'b010_11100, 8'b010_11101, 8'b000_10101, 8'b000_10101,
                 8'b000_10101, 8'b101_00101};
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("pend[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_push_restore();
        logic [6:0] stim [12];
        logic [7:0] expv [12];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b10_000_00, 7'b01_101_00, 7'b00_000_10, 7'b10_000_00,
                 7'b01_010_00, 7'b00_000_01, 7'b10_000_00, 7'b01_011_10,
                 7'b10_000_00, 7'b01_100_00, 7'b00_000_01, 7'b00_000_11};
        expv = '{8'b000_10100, 8'b101_00100, 8'b101_00000, 8'b101_10000,
                 8'b010_00000, 8'b101_00100, 8'b101_10100, 8'b011_00000,
                 8'b011_10000, 8'b100_00000, 8'b011_00100, 8'b011_00100};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("restore[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_stack_full();
        logic [6:0] stim [14];
        logic [7:0] expv [14];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b10_000_00, 7'b01_001_10, 7'b10_000_00, 7'b01_010_10,
                 7'b10_000_00, 7'b01_011_10, 7'b10_000_00, 7'b01_100_10,
                 7'b10_000_00, 7'b01_110_10, 7'b00_000_01, 7'b00_000_01,
                 7'b00_000_01, 7'b00_000_01};
        expv = '{8'b000_10100, 8'b001_00000, 8'b001_10000, 8'b010_00000,
                 8'b010_10000, 8'b011_00000, 8'b011_10000, 8'b100_00010,
                 8'b100_10010, 8'b110_00011, 8'b100_00001, 8'b011_00001,
                 8'b010_00001, 8'b001_00101};
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("stackfull[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_pop_underflow();
        expEntry_t  e;
        logic [7:0] got;
        apply_reset();
        drive(7'b00_000_01);
        sbQ.push_back('{"pop_empty", 8'b000_00101});
        @(negedge clk);
        e = sbQ.pop_front();
        got = obsVec();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
        end
    endtask

    task automatic test_alu_underflow();
        logic [6:0] stim [3];
        logic [7:0] expv [3];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b01_111_00, 7'b10_000_00, 7'b01_111_00};
        expv = '{8'b000_00101, 8'b000_10101, 8'b111_00101};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("aluunder[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
    endtask

    task automatic test_pop_override_and_reset();
        logic [6:0] stim [8];
        logic [7:0] expv [8];
        expEntry_t  e;
        logic [7:0] got;
        stim = '{7'b00_000_10, 7'b10_000_00, 7'b10_000_00, 7'b01_111_01,
                 7'b01_011_00, 7'b01_111_00, 7'b10_000_00, 7'b00_000_10};
        expv = '{8'b000_00000, 8'b000_10000, 8'b000_10000, 8'b000_10100,
                 8'b011_00100, 8'b011_00101, 8'b011_10101, 8'b011_10001};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(stim[i]);
            sbQ.push_back('{$sformatf("override[%0d]", i), expv[i]});
            @(negedge clk);
            e = sbQ.pop_front();
            got = obsVec();
            checks++;
            if (got !== e.val) begin
                errors++;
                $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
            end
        end
        // Asynchronous reset between clock edges must clear everything at once.
        drive(7'b0);
        #2 rst_n = 1'b0;
        sbQ.push_back('{"async_reset", 8'b000_00100});
        #1;
        e = sbQ.pop_front();
        got = obsVec();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // With nothing pending, an ALU result must not be captured.
        drive(7'b01_111_00);
        sbQ.push_back('{"post_reset_alu", 8'b000_00101});
        @(negedge clk);
        e = sbQ.pop_front();
        got = obsVec();
        checks++;
        if (got !== e.val) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", e.name, got, e.val);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(7'b0);
        test_reset();
        test_basic_update();
        test_pending_limit();
        test_push_restore();
        test_stack_full();
        test_pop_underflow();
        test_alu_underflow();
        test_pop_override_and_reset();
        drive(7'b0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
